// File: rtl/bsr_meta_pkg.sv
// Shared constants for the BSR metadata server: request address map,
// one-hot FSM encoding and table-select codes.
package bsr_meta_pkg;

   // First request address that maps onto the col_idx table.
   localparam int COL_BASE = 128;

   localparam logic [3:0] ST_IDLE = 4'b0001;
   localparam logic [3:0] ST_READ = 4'b0010;
   localparam logic [3:0] ST_RESP = 4'b0100;
   localparam logic [3:0] ST_GAP  = 4'b1000;

   localparam logic TBL_ROW = 1'b0;
   localparam logic TBL_COL = 1'b1;

   // True when a request address falls outside the populated part of its table.
   function automatic logic addr_out_of_range(input logic [31:0] addr,
                                              input int          row_depth,
                                              input int          col_depth);
      if (addr >= 32'(COL_BASE))
         return (addr - 32'(COL_BASE)) >= 32'(col_depth);
      return addr >= 32'(row_depth);
   endfunction

endpackage

// File: rtl/meta_sram.sv
// Single-port synchronous RAM, one-cycle read latency. A write in the same
// cycle as a read wins; the read data register then holds its old value.
module meta_sram #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 128,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write has priority; read data only moves on a pure read.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we)
            mem[addr] <= wdata;
         else
            rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/bsr_meta_server.sv
// Serves row_ptr / col_idx metadata words to the sparse scheduler.
// State table:
//   IDLE | waiting for meta_ren; accepting captures the address
//   READ | table read issued; held here while a loader write hits the same table
//   RESP | table word on meta_rdata, meta_rvalid high
//   GAP  | one dead cycle so the requester's stale address is not re-issued
module bsr_meta_server
   import bsr_meta_pkg::*;
#(
   parameter int ROW_DEPTH = 128,
   parameter int COL_DEPTH = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        meta_ren,
   input  logic [31:0] meta_raddr,
   input  logic        meta_ready,
   output logic [31:0] meta_rdata,
   output logic        meta_rvalid,
   input  logic        cfg_wr_en,
   input  logic        cfg_wr_sel,
   input  logic [9:0]  cfg_wr_addr,
   input  logic [31:0] cfg_wr_data,
   output logic        busy,
   output logic        oob_err,
   input  logic        err_clr,
   output logic [31:0] req_count
);

   localparam int RAW  = (ROW_DEPTH > 1) ? $clog2(ROW_DEPTH) : 1;
   localparam int CAW  = (COL_DEPTH > 1) ? $clog2(COL_DEPTH) : 1;
   localparam int IDXW = (RAW > CAW) ? RAW : CAW;

   logic [3:0]      state, state_nxt;
   logic            req_sel_q, req_oob_q;
   logic [IDXW-1:0] req_idx_q;
   logic [31:0]     rdata_q, rd_word, row_q, col_q;
   logic            accept, in_read, in_resp;
   logic            rd_row, rd_col, row_we, col_we, wr_ok, stall;
   logic [RAW-1:0]  row_addr;
   logic [CAW-1:0]  col_addr;
   logic            unused_ok;

   // meta_ready is informational; responses never wait on it.
   assign unused_ok = &{1'b0, meta_ready};

   assign wr_ok  = (cfg_wr_sel == TBL_COL) ? (32'(cfg_wr_addr) < 32'(COL_DEPTH))
                                           : (32'(cfg_wr_addr) < 32'(ROW_DEPTH));
   assign row_we = cfg_wr_en & wr_ok & (cfg_wr_sel == TBL_ROW);
   assign col_we = cfg_wr_en & wr_ok & (cfg_wr_sel == TBL_COL);

   assign rd_row = in_read & (req_sel_q == TBL_ROW) & ~req_oob_q;
   assign rd_col = in_read & (req_sel_q == TBL_COL) & ~req_oob_q;
   assign stall  = (rd_row & row_we) | (rd_col & col_we);

   assign row_addr = row_we ? cfg_wr_addr[RAW-1:0] : req_idx_q[RAW-1:0];
   assign col_addr = col_we ? cfg_wr_addr[CAW-1:0] : req_idx_q[CAW-1:0];

   assign rd_word = req_oob_q ? 32'd0 : ((req_sel_q == TBL_COL) ? col_q : row_q);

   meta_sram #(.WIDTH(32), .DEPTH(ROW_DEPTH)) u_row_ptr (
      .clk   (clk),
      .en    (row_we | rd_row),
      .we    (row_we),
      .addr  (row_addr),
      .wdata (cfg_wr_data),
      .rdata (row_q)
   );

   meta_sram #(.WIDTH(32), .DEPTH(COL_DEPTH)) u_col_idx (
      .clk   (clk),
      .en    (col_we | rd_col),
      .we    (col_we),
      .addr  (col_addr),
      .wdata (cfg_wr_data),
      .rdata (col_q)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state: READ stays put while the loader owns the same table.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (meta_ren) state_nxt = ST_READ;
         ST_READ: if (!stall)   state_nxt = ST_RESP;
         ST_RESP: state_nxt = ST_GAP;
         ST_GAP:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs; meta_rdata shows the table word in RESP and the held copy otherwise.
   always_comb begin
      in_read     = (state == ST_READ);
      in_resp     = (state == ST_RESP);
      accept      = (state == ST_IDLE) & meta_ren;
      meta_rvalid = in_resp;
      busy        = (state != ST_IDLE);
      meta_rdata  = in_resp ? rd_word : rdata_q;
   end

   // Request capture, response hold, sticky error and request counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_count <= 32'd0;
         oob_err   <= 1'b0;
         rdata_q   <= 32'd0;
         req_sel_q <= TBL_ROW;
         req_oob_q <= 1'b0;
         req_idx_q <= '0;
      end else begin
         if (accept) begin
            req_count <= req_count + 32'd1;
            req_sel_q <= (meta_raddr >= 32'(COL_BASE)) ? TBL_COL : TBL_ROW;
            req_oob_q <= addr_out_of_range(meta_raddr, ROW_DEPTH, COL_DEPTH);
            req_idx_q <= IDXW'((meta_raddr >= 32'(COL_BASE)) ? (meta_raddr - 32'(COL_BASE))
                                                              : meta_raddr);
         end
         if (in_resp)
            rdata_q <= rd_word;
         // A new error in the same cycle as err_clr leaves the flag set.
         oob_err <= (oob_err & ~err_clr)
                  | (cfg_wr_en & ~wr_ok)
                  | (accept & addr_out_of_range(meta_raddr, ROW_DEPTH, COL_DEPTH));
      end
   end

endmodule

// File: doc/bsr_meta_server.md
BSR_META_SERVER -- requirements
Module: bsr_meta_server

Interface
REQ-001 Parameters SHALL be ROW_DEPTH=128 (row_ptr entries), COL_DEPTH=1024 (col_idx entries) and COL_BASE=128 (first col_idx address in request space).
REQ-002 Port clk, input, 1: single clock; every register SHALL update on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port meta_ren, input, 1: scheduler read request; may be held high across many cycles.
REQ-005 Port meta_raddr, input, 32: request address; values below COL_BASE select row_ptr, values at or above COL_BASE select col_idx[addr-COL_BASE].
REQ-006 Port meta_ready, input, 1: scheduler accepts data; informational only, SHALL NOT gate responses.
REQ-007 Port meta_rdata, output, 32: response word.
REQ-008 Port meta_rvalid, output, 1: one-cycle response strobe.
REQ-009 Port cfg_wr_en, input, 1: table write strobe from the DMA loader.
REQ-010 Port cfg_wr_sel, input, 1: table select; 0 = row_ptr, 1 = col_idx.
REQ-011 Port cfg_wr_addr, input, 10: table-local write index.
REQ-012 Port cfg_wr_data, input, 32: write data.
REQ-013 Port busy, output, 1: a request is in flight, meaning the FSM is not in IDLE.
REQ-014 Port oob_err, output, 1: sticky flag for an out-of-range read or write.
REQ-015 Port err_clr, input, 1: clears oob_err.
REQ-016 Port req_count, output, 32: number of accepted requests; wraps modulo 2^32.

Function
REQ-017 The FSM SHALL have states IDLE, READ, RESP and GAP, one-hot encoded.
REQ-018 IDLE: with meta_ren=1, the block SHALL capture meta_raddr, increment req_count and move to READ; otherwise it stays in IDLE.
REQ-019 READ: the block SHALL issue a one-cycle read to the selected table, then move to RESP.
REQ-020 RESP: the block SHALL register the table output into meta_rdata, assert meta_rvalid for exactly that cycle, then move to GAP.
REQ-021 GAP: one cycle, ignoring meta_ren, so the requester's stale registered address is not re-issued; then move to IDLE.
REQ-022 Latency SHALL be meta_rvalid high in the 2nd cycle after the accepting edge; minimum request spacing is 4 cycles.
REQ-023 meta_rdata SHALL hold its value until the next RESP, because the consumer reads it again in the cycle after meta_rvalid.
REQ-024 meta_ren seen in READ, RESP or GAP SHALL be ignored; at most one request is outstanding.
REQ-025 An out-of-range request (row address at or above ROW_DEPTH but below COL_BASE, or col index at or above COL_DEPTH) SHALL return meta_rdata=0 with normal timing and set oob_err.
REQ-026 cfg_wr_en SHALL write the selected table in the same cycle.
REQ-027 An out-of-range write SHALL be dropped and SHALL set oob_err.
REQ-028 If a write and a READ-state access hit the same table in one cycle, the write SHALL win and the block SHALL stay in READ, adding 1 cycle of latency per conflicting cycle; a write to the other table SHALL NOT stall.
REQ-029 If err_clr and a new error occur in the same cycle, oob_err SHALL end that cycle set.

Reset
REQ-030 When rst is high, the FSM SHALL enter IDLE and meta_rvalid, busy, oob_err and req_count SHALL be 0.
REQ-031 When rst is high, meta_rdata SHALL be 0.
REQ-032 Table contents SHALL NOT be cleared by reset.
REQ-033 A reset mid-request SHALL drop the request with no meta_rvalid pulse afterwards.

Structure
REQ-034 Package bsr_meta_pkg SHALL hold COL_BASE, the state encoding localparams, and the table-select constants TBL_ROW and TBL_COL.
REQ-035 Sub-module meta_sram SHALL be a single-port synchronous RAM with 1-cycle read latency, write priority, and parameters WIDTH and DEPTH; it is instantiated once per table.

Verification
REQ-036 Load row_ptr={0,2,2,5}, then hold meta_ren=1 with addr=1 -> meta_rvalid pulses 2 cycles after acceptance with rdata=2; rdata holds 2 until the next response.
REQ-037 Hold meta_ren continuously with addr 0 then 1, changing 1 cycle after rvalid -> responses are 0 then 2; the stale addr 0 in the GAP cycle produces no response.
REQ-038 Write col_idx[3]=7, then request addr 131 -> rdata=7; request addr 200 with COL_DEPTH=64 -> rdata=0 and oob_err=1; err_clr -> oob_err=0.
REQ-039 A row_ptr write in the READ cycle of a row_ptr request -> rvalid is delayed to 3 cycles; a col_idx write in the same cycle -> rvalid stays at 2 cycles.
REQ-040 Assert rst in the READ state -> no rvalid, busy=0 and req_count=0 the next cycle; table data is still readable afterwards.
